fetch_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Its registered `Instr_ID` is the word the ID-stage decoder consumes. It accepts stall and branch/jump redirects from ID and honours the MIPS branch delay slot.

---
 rtl/mips_pkg.sv | 16 +
 rtl/if_id_reg.sv | 48 ++++
 rtl/fetch_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by the fetch stage and its IF/ID register.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    SEQ     = 1'b0,
    PENDING = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 1-cycle latency, loads a fetched word or a bubble.
// Holds its contents while i_en is low (ID stalled).
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [ADDR_W-1:0]  o_pc8,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pc8;
  logic               r_valid;

  // A bubble keeps PC_ID/PC8_ID so the last real address stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc8   <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      if (i_load) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
        r_pc8   <= i_pc + 32'd8;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc8   = r_pc8;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, imem request and IF/ID register; FC-to-Instr_ID latency 1 edge.
// Stall freezes PC and IF/ID while the fetch repeats; a slow delay-slot fetch parks the target in PENDING.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               stall_ID,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [INSTR_W-1:0] Instr_ID,
  output logic [ADDR_W-1:0]  PC_ID,
  output logic [ADDR_W-1:0]  PC8_ID,
  output logic               valid_ID,
  output logic               fetch_busy
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] w_pend_nxt;
  logic              r_req;

  logic              w_fc;
  logic              w_advance;
  logic              w_redir_acc;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_plus4;

  assign w_fc        = r_req && imem_ready;
  assign w_advance   = w_fc && !stall_ID;
  assign w_redir_acc = redirect && !stall_ID;
  assign w_target    = redirect_target & 32'hFFFF_FFFC;
  assign w_pc_plus4  = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= SEQ;
      r_pc          <= RESET_PC;
      r_pend_target <= '0;
      r_req         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend_target <= w_pend_nxt;
      r_req         <= 1'b1;
    end
  end

  // Redirects in PENDING are ignored: ID can only hold bubbles there.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_target;
    case (r_state)
      SEQ: begin
        if (w_advance) begin
          w_pc_nxt = w_redir_acc ? w_target : w_pc_plus4;
        end else if (w_redir_acc) begin
          w_state_nxt = PENDING;
          w_pend_nxt  = w_target;
        end
      end
      PENDING: begin
        if (w_advance) begin
          w_pc_nxt    = r_pend_target;
          w_state_nxt = SEQ;
        end
      end
      default: w_state_nxt = SEQ;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (!stall_ID),
    .i_load  (w_fc),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_instr (Instr_ID),
    .o_pc    (PC_ID),
    .o_pc8   (PC8_ID),
    .o_valid (valid_ID)
  );

  assign imem_addr  = r_pc;
  assign imem_req   = r_req;
  assign fetch_busy = r_req && !imem_ready;

  a_no_redirect_in_pending: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(r_state == PENDING && redirect && !stall_ID)
  );

endmodule
